// File: rtl/debouncer_pkg.sv
// Shared helpers for the debouncer slice: counter width sizing.
package debouncer_pkg;

  // Bits needed to hold 0 .. count-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned count);
    return (count <= 1) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: registers a level vector and flags 0->1 transitions
// combinationally in the same cycle the level rises.
module edge_detector #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] level_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] prev_q, prev_d;

  // Next-state of the history register is simply the current level.
  always_comb begin
    prev_d = level_i;
  end

  // Previous-level register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/debouncer.sv
// Per-bit button debouncer. A shared sample counter produces a tick every
// SAMPLE_CNT_MAX cycles; each bit needs PULSE_CNT_MAX consecutive high ticks
// (with no low cycle in between) before its debounced level asserts.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SAMPLE_CNT_MAX = 62500,
  parameter int unsigned PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] rising_pulse
);

  localparam int unsigned SampleW = cnt_width(SAMPLE_CNT_MAX);
  localparam int unsigned PulseW  = cnt_width(PULSE_CNT_MAX + 1);

  localparam logic [SampleW-1:0] SampleLast = SampleW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PulseW-1:0]  PulseMax   = PulseW'(PULSE_CNT_MAX);

  logic [SampleW-1:0] sample_cnt_q, sample_cnt_d;
  logic               sample_tick;

  // Tick on the last count of the window, then wrap; with a window of one
  // the count stays at zero and the tick is permanently high.
  always_comb begin
    sample_tick  = (sample_cnt_q == SampleLast);
    sample_cnt_d = sample_tick ? '0 : sample_cnt_q + SampleW'(1);
  end

  // Shared sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [PulseW-1:0] cnt_q, cnt_d;

    // Any low cycle clears, even on a tick; high ticks count up to saturation.
    always_comb begin
      cnt_d = cnt_q;
      if (!glitchy_signal[i]) begin
        cnt_d = '0;
      end else if (sample_tick && (cnt_q != PulseMax)) begin
        cnt_d = cnt_q + PulseW'(1);
      end
    end

    // Per-bit saturating qualification counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign debounced_signal[i] = (cnt_q == PulseMax);
  end

  edge_detector #(
    .WIDTH(WIDTH)
  ) u_edge_detector (
    .clk    (clk),
    .rst    (rst),
    .level_i(debounced_signal),
    .rise_o (rising_pulse)
  );

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3).
// Expected outputs per cycle are pushed to a scoreboard queue as stimulus is
// driven, then popped and compared once the DUT outputs have settled.
module tb_debouncer;

  localparam int unsigned W = 2;
  localparam int unsigned S = 4;
  localparam int unsigned P = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] glitchy = '0;
  logic [W-1:0] deb;
  logic [W-1:0] pulse;

  typedef struct {
    string        name;
    int           cyc;
    logic [W-1:0] deb;
    logic [W-1:0] pul;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  debouncer #(
    .WIDTH         (W),
    .SAMPLE_CNT_MAX(S),
    .PULSE_CNT_MAX (P)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .glitchy_signal  (glitchy),
    .debounced_signal(deb),
    .rising_pulse    (pulse)
  );

  // Reset across one rising edge; returns at the negedge where cycle 0 begins.
  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    glitchy = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    // Reset state while rst is held.
    @(negedge clk);
    rst     = 1'b1;
    glitchy = 2'b01;
    e.name = "reset_state"; e.cyc = -1; e.deb = 2'b00; e.pul = 2'b00;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    total++;
    if (deb !== e.deb || pulse !== e.pul)
      $display("FAIL %s cyc=%0d debounced=%b want=%b pulse=%b want=%b",
               e.name, e.cyc, deb, e.deb, pulse, e.pul);
    else passed++;
    // Run to the pulse cycle, then assert reset between edges.
    do_reset();
    for (int n = 0; n <= 12; n++) begin
      glitchy = 2'b01;
      e.name = "reset_run"; e.cyc = n;
      e.deb = (n >= 12) ? 2'b01 : 2'b00;
      e.pul = (n == 12) ? 2'b01 : 2'b00;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      total++;
      if (deb !== e.deb || pulse !== e.pul)
        $display("FAIL %s cyc=%0d debounced=%b want=%b pulse=%b want=%b",
                 e.name, e.cyc, deb, e.deb, pulse, e.pul);
      else passed++;
      if (n < 12) @(negedge clk);
    end
    rst = 1'b1;
    e.name = "reset_async"; e.cyc = 12; e.deb = 2'b00; e.pul = 2'b00;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    total++;
    if (deb !== e.deb || pulse !== e.pul)
      $display("FAIL %s cyc=%0d debounced=%b want=%b pulse=%b want=%b",
               e.name, e.cyc, deb, e.deb, pulse, e.pul);
    else passed++;
  endtask

  task automatic test_clean_press();
    exp_t e;
    do_reset();
    for (int n = 0; n <= 20; n++) begin
      glitchy = 2'b01;
      e.name = "clean_press"; e.cyc = n;
      e.deb = (n >= 12) ? 2'b01 : 2'b00;
      e.pul = (n == 12) ? 2'b01 : 2'b00;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      total++;
      if (deb !== e.deb || pulse !== e.pul)
        $display("FAIL %s cyc=%0d debounced=%b want=%b pulse=%b want=%b",
                 e.name, e.cyc, deb, e.deb, pulse, e.pul);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_bounce();
    exp_t e;
    do_reset();
    for (int n = 0; n <= 26; n++) begin
      glitchy = (n == 10) ? 2'b00 : 2'b01;
      e.name = "bounce"; e.cyc = n;
      e.deb = (n >= 20) ? 2'b01 : 2'b00;
      e.pul = (n == 20) ? 2'b01 : 2'b00;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      total++;
      if (deb !== e.deb || pulse !== e.pul)
        $display("FAIL %s cyc=%0d debounced=%b want=%b pulse=%b want=%b",
                 e.name, e.cyc, deb, e.deb, pulse, e.pul);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_hold_release();
    exp_t e;
    int   pulses = 0;
    do_reset();
    for (int n = 0; n <= 45; n++) begin
      glitchy = (n < 40) ? 2'b01 : 2'b00;
      e.name = "hold_release"; e.cyc = n;
      e.deb = (n >= 12 && n <= 40) ? 2'b01 : 2'b00;
      e.pul = (n == 12) ? 2'b01 : 2'b00;
      sb.push_back(e);
      #1;
      if (pulse[0]) pulses++;
      e = sb.pop_front();
      total++;
      if (deb !== e.deb || pulse !== e.pul)
        $display("FAIL %s cyc=%0d debounced=%b want=%b pulse=%b want=%b",
                 e.name, e.cyc, deb, e.deb, pulse, e.pul);
      else passed++;
      @(negedge clk);
    end
    total++;
    if (pulses !== 1)
      $display("FAIL hold_pulse_count got=%0d want=1", pulses);
    else passed++;
  endtask

  task automatic test_reset_mid_press();
    exp_t e;
    do_reset();
    for (int n = 0; n <= 10; n++) begin
      glitchy = 2'b01;
      e.name = "midreset_pre"; e.cyc = n; e.deb = 2'b00; e.pul = 2'b00;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      total++;
      if (deb !== e.deb || pulse !== e.pul)
        $display("FAIL %s cyc=%0d debounced=%b want=%b pulse=%b want=%b",
                 e.name, e.cyc, deb, e.deb, pulse, e.pul);
      else passed++;
      if (n < 10) @(negedge clk);
    end
    // Pulse reset in cycle 10 with the input still high.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int m = 0; m <= 16; m++) begin
      glitchy = 2'b01;
      e.name = "midreset_post"; e.cyc = m;
      e.deb = (m >= 12) ? 2'b01 : 2'b00;
      e.pul = (m == 12) ? 2'b01 : 2'b00;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      total++;
      if (deb !== e.deb || pulse !== e.pul)
        $display("FAIL %s cyc=%0d debounced=%b want=%b pulse=%b want=%b",
                 e.name, e.cyc, deb, e.deb, pulse, e.pul);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_independence();
    exp_t e;
    do_reset();
    for (int n = 0; n <= 22; n++) begin
      // bit1 starts 5 cycles later; its ticks fall in 7, 11, 15.
      glitchy = {(n >= 5) ? 1'b1 : 1'b0, 1'b1};
      e.name = "independence"; e.cyc = n;
      e.deb = {(n >= 16) ? 1'b1 : 1'b0, (n >= 12) ? 1'b1 : 1'b0};
      e.pul = {(n == 16) ? 1'b1 : 1'b0, (n == 12) ? 1'b1 : 1'b0};
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      total++;
      if (deb !== e.deb || pulse !== e.pul)
        $display("FAIL %s cyc=%0d debounced=%b want=%b pulse=%b want=%b",
                 e.name, e.cyc, deb, e.deb, pulse, e.pul);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_release();
    test_reset_mid_press();
    test_independence();
    total++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
